// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   kp_state_e  - scanner FSM states
//   KEY_MAP     - hex digit per key, indexed by {row, col}
//   first_low() - lowest-index active-low row in a row vector
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  // Row-major: entry {row, col}. Row 3 carries E(*), 0, F(#), D.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Lowest-index low row wins; result is don't-care when no row is low.
  function automatic logic [1:0] first_low(input logic [3:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (!rows[i-1]) idx = 2'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: consecutive-clock stability counter.
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   clr_i   - clear the count
//   inc_i   - the watched level is in its qualifying state this clock
//   done_o  - this clock completes DEB_CYC consecutive qualifying clocks
// The count self-clears on completion.
module keypad_debounce #(
  parameter int unsigned DEB_CYC = 20000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o
);

  localparam int unsigned CNT_W = $clog2(DEB_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = inc_i && (cnt_q == CNT_W'(DEB_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || done_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce.
//   clk       - system clock
//   reset_n   - asynchronous active-low reset
//   row_in    - keypad rows, active-low, asynchronous
//   col_out   - column drive, active-low, one-hot-low
//   key_code  - hex digit of last accepted key
//   key_valid - one-clock pulse per accepted key
//   key_held  - high while a key is accepted and not yet released
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat pulses while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_CYC    = 20000,
  parameter int unsigned REPEAT_DLY = 10000000,
  parameter int unsigned REPEAT_PER = 2500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if (SCAN_DIV < 4 || DEB_CYC < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
    $error("keypad_scanner: parameter below minimum");
  end

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  kp_state_e        state_q, state_d;
  logic [3:0]       row_meta_q, row_sync_q;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             level;
  logic             deb_clr, deb_inc, deb_done;
  logic             rep_fire;

  // Synchronized level of the latched row: 0 = pressed, 1 = released.
  assign level = row_sync_q[row_q];

  keypad_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_debounce (
    .clk_i (clk),
    .rst_ni(reset_n),
    .clr_i (deb_clr),
    .inc_i (deb_inc),
    .done_o(deb_done)
  );

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_first_q, rep_first_d;

  // Counts only while the key stays down in PRESSED; any other clock
  // re-arms the initial delay.
  always_comb begin
    rep_d       = '0;
    rep_first_d = 1'b1;
    rep_fire    = 1'b0;
    if (state_q == ST_PRESSED && !level) begin
      rep_first_d = rep_first_q;
      if (rep_q == (rep_first_q ? REP_W'(REPEAT_DLY - 1) : REP_W'(REPEAT_PER - 1))) begin
        rep_fire    = 1'b1;
        rep_first_d = 1'b0;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    div_d   = div_q;
    code_d  = code_q;
    valid_d = 1'b0;
    deb_clr = 1'b1;
    deb_inc = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          div_d = '0;
          if (row_sync_q != '1) begin
            row_d   = first_low(row_sync_q);
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!level) begin
          deb_clr = 1'b0;
          deb_inc = 1'b1;
          if (deb_done) begin
            code_d  = KEY_MAP[{row_q, col_q}];
            valid_d = 1'b1;
            state_d = ST_PRESSED;
          end
        end else begin
          col_d   = col_q + 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_PRESSED: begin
        if (level) state_d = ST_RELEASE;
        else       valid_d = rep_fire;
      end
      ST_RELEASE: begin
        if (level) begin
          deb_clr = 1'b0;
          deb_inc = 1'b1;
          if (deb_done) begin
            col_d   = col_q + 1'b1;
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_PRESSED;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      state_q    <= ST_SCAN;
      col_q      <= '0;
      row_q      <= '0;
      div_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      div_q      <= div_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clocks each column is driven before sampling (min 4).
REQ-002 SHALL have parameter DEB_CYC, default 20000, clocks a row level must stay stable to count as press or release (min 2).
REQ-003 SHALL have parameter REPEAT_DLY, default 10000000, clocks held before the first auto-repeat (used only with KEYPAD_REPEAT_EN).
REQ-004 SHALL have parameter REPEAT_PER, default 2500000, clocks between auto-repeats (used only with KEYPAD_REPEAT_EN).
REQ-005 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port row_in  input  4  keypad rows, active-low (pulled up externally), asynchronous.
REQ-008 SHALL have port col_out  output  4  column drive, active-low, one-hot-low.
REQ-009 SHALL have port key_code  output  4  hex digit of last accepted key; feeds the lock FSM digit input.
REQ-010 SHALL have port key_valid  output  1  one-cycle pulse per accepted key.
REQ-011 SHALL have port key_held  output  1  high while a key is accepted and not yet released.

Function
REQ-012 SHALL pass row_in through a 2-flop synchronizer; all row decisions use the synchronized value.
REQ-013 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-014 In SCAN, SHALL drive one column low for SCAN_DIV clocks, sample rows on the last clock, then advance column 0->1->2->3->0.
REQ-015 In SCAN, if any sampled row is low, SHALL latch column and lowest-index low row, hold that column, enter DEBOUNCE.
REQ-016 In DEBOUNCE, SHALL count DEB_CYC consecutive clocks with the latched row low; any high sample returns to SCAN at the next column with counter cleared.
REQ-017 On DEBOUNCE completion, SHALL update key_code, pulse key_valid for exactly one clock in the same cycle, enter PRESSED.
REQ-018 Key map (row,col): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E(*) 0 F(#) D.
REQ-019 In PRESSED, SHALL hold the column and move to RELEASE on the first high sample of the latched row.
REQ-020 In RELEASE, SHALL require DEB_CYC consecutive high samples, then enter SCAN at the next column; a low sample returns to PRESSED without a new key_valid.
REQ-021 key_held SHALL be high exactly in PRESSED and RELEASE.
REQ-022 Additional keys pressed while in DEBOUNCE/PRESSED/RELEASE SHALL be ignored.
REQ-023 key_code SHALL hold its value until the next accepted key.
REQ-024 Counters SHALL be wide enough for the maximum parameter value; no wrap before terminal count.

Reset
REQ-025 reset_n low SHALL force state SCAN, column 0 (col_out=4'b1110), all counters and synchronizer flops to idle (rows high), key_code=4'h0, key_valid=0, key_held=0.
REQ-026 Reset asserted mid-press SHALL abort without a key_valid pulse; a key still held after release of reset SHALL be debounced afresh and accepted once.

Configuration
REQ-027 With KEYPAD_REPEAT_EN defined, SHALL pulse key_valid (same key_code) after REPEAT_DLY clocks in PRESSED, then every REPEAT_PER clocks while PRESSED; the repeat counter clears on entering RELEASE.
REQ-028 Without KEYPAD_REPEAT_EN, SHALL emit exactly one key_valid per press and omit repeat counter logic.

Structure
REQ-029 Package keypad_pkg SHALL hold the state enumeration and the 16-entry key map constant.
REQ-030 The stability counter (clear, count, terminal flag) SHALL be sub-module keypad_debounce, shared by DEBOUNCE and RELEASE.

Verification (SCAN_DIV=4, DEB_CYC=8, REPEAT_DLY=32, REPEAT_PER=16)
REQ-031 Reset then idle rows=4'hF -> col_out cycles 1110,1101,1011,0111 every 4 clocks; key_valid never pulses.
REQ-032 Hold row1 low while col2 driven for 20 clocks -> one key_valid with key_code=4'h6; key_held high until 8 clocks after release.
REQ-033 Row0 low on col0 for 5 clocks only -> no key_valid; scan resumes at col1.
REQ-034 Row3 pressed on col1 with a 3-clock release glitch inside PRESSED -> single key_valid, key_code=4'h0.
REQ-035 With KEYPAD_REPEAT_EN, hold row2/col3 for 80 clocks -> pulses with key_code=4'hC at acceptance, +32, +48, +64.
REQ-036 reset_n low during DEBOUNCE of row0/col0 -> outputs at reset values, no pulse; key still held after reset -> exactly one key_valid, key_code=4'h1.
